// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - load/store op codes, FSM state encoding and op classification helpers
package mem_pkg;

    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_SW  = 5'b10101;
    localparam logic [4:0] OP_LB  = 5'b10110;
    localparam logic [4:0] OP_LH  = 5'b10111;
    localparam logic [4:0] OP_LBU = 5'b11000;
    localparam logic [4:0] OP_LHU = 5'b11001;
    localparam logic [4:0] OP_SB  = 5'b11010;
    localparam logic [4:0] OP_SH  = 5'b11011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_load(input logic [4:0] op);
        is_load = (op == OP_LW) || (op == OP_LB) || (op == OP_LH) ||
                  (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        is_store = (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    // Non-memory ops report SZ_WORD; callers only use the size for memory ops.
    function automatic logic [1:0] op_size(input logic [4:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            default:              op_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - extracts the addressed byte/half lane from read data and sign/zero extends it
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 2
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [4:0]        op,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (op)
            OP_LB:   data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            OP_LBU:  data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            OP_LH:   data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            OP_LHU:  data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - load/store stage with req/ack bus handshake and timeout
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned half/word accesses raise BusErr_o without a bus request.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Valid_i,
    input  logic [4:0]          ALUop_i,
    input  logic                WriteReg_i,
    input  logic [RA_W-1:0]     WriteDataAddr_i,
    input  logic [DATA_W-1:0]   WriteData_i,
    input  logic [ADDR_W-1:0]   MemAddr_i,
    input  logic [DATA_W-1:0]   Reg_i,
    output logic                Stall_o,
    output logic                MemReq_o,
    output logic                MemWE_o,
    output logic [DATA_W/8-1:0] MemBE_o,
    output logic [ADDR_W-1:0]   MemAddr_o,
    output logic [DATA_W-1:0]   MemData_o,
    input  logic                MemAck_i,
    input  logic [DATA_W-1:0]   MemData_i,
    output logic                Valid_o,
    output logic                WriteReg_o,
    output logic [RA_W-1:0]     WriteDataAddr_o,
    output logic [DATA_W-1:0]   WriteData_o,
    output logic                BusErr_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        op_q;
    logic [LANE_W-1:0] lane_q;
    logic              wreg_q;
    logic [RA_W-1:0]   wa_q;

    logic              mem_op;
    logic              start;
    logic              bad;
    logic [LANE_W-1:0] raw_lane;
    logic [LANE_W-1:0] lane;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] load_data;

    assign mem_op  = is_load(ALUop_i) || is_store(ALUop_i);
    assign start   = (state == IDLE) && Valid_i && mem_op;
    assign Stall_o = start || (state == BUSY);

    // Lane selection forces the access aligned to its size; misalignment is judged separately.
    always_comb begin
        raw_lane = MemAddr_i[LANE_W-1:0];
        lane     = '0;
        be       = '1;
        wdata    = Reg_i;
        case (op_size(ALUop_i))
            SZ_BYTE: begin
                lane  = raw_lane;
                be    = BE_W'(1) << raw_lane;
                wdata = DATA_W'(Reg_i[7:0]) << {raw_lane, 3'b000};
            end
            SZ_HALF: begin
                lane  = {raw_lane[LANE_W-1:1], 1'b0};
                be    = BE_W'(3) << lane;
                wdata = DATA_W'(Reg_i[15:0]) << {lane, 3'b000};
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        case (op_size(ALUop_i))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = MemAddr_i[0];
            default: bad = |MemAddr_i[LANE_W-1:0];
        endcase
    end
`else
    assign bad = 1'b0;
`endif

    mem_load_align #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_align (
        .rdata (MemData_i),
        .lane  (lane_q),
        .op    (op_q),
        .data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_q            <= '0;
            lane_q          <= '0;
            wreg_q          <= 1'b0;
            wa_q            <= '0;
            MemReq_o        <= 1'b0;
            MemWE_o         <= 1'b0;
            MemBE_o         <= '0;
            MemAddr_o       <= '0;
            MemData_o       <= '0;
            Valid_o         <= 1'b0;
            WriteReg_o      <= 1'b0;
            WriteDataAddr_o <= '0;
            WriteData_o     <= '0;
            BusErr_o        <= 1'b0;
        end else begin
            Valid_o    <= 1'b0;
            WriteReg_o <= 1'b0;
            BusErr_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Valid_i && !mem_op) begin
                        Valid_o         <= 1'b1;
                        WriteReg_o      <= WriteReg_i;
                        WriteDataAddr_o <= WriteDataAddr_i;
                        WriteData_o     <= WriteData_i;
                    end else if (start && bad) begin
                        state           <= DONE;
                        Valid_o         <= 1'b1;
                        BusErr_o        <= 1'b1;
                        WriteDataAddr_o <= WriteDataAddr_i;
                        WriteData_o     <= '0;
                    end else if (start) begin
                        state     <= BUSY;
                        cnt       <= CNT_W'(1);
                        MemReq_o  <= 1'b1;
                        MemWE_o   <= is_store(ALUop_i);
                        MemBE_o   <= be;
                        MemAddr_o <= {MemAddr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        MemData_o <= wdata;
                        op_q      <= ALUop_i;
                        lane_q    <= lane;
                        wreg_q    <= WriteReg_i && is_load(ALUop_i);
                        wa_q      <= WriteDataAddr_i;
                    end
                end
                BUSY: begin
                    // cnt counts BUSY cycles seen so far, so the abort lands after exactly MAX_WAIT of them.
                    if (MemAck_i) begin
                        state           <= DONE;
                        MemReq_o        <= 1'b0;
                        Valid_o         <= 1'b1;
                        WriteReg_o      <= wreg_q;
                        WriteDataAddr_o <= wa_q;
                        WriteData_o     <= is_load(op_q) ? load_data : '0;
                    end else if (cnt == CNT_MAX) begin
                        state           <= DONE;
                        MemReq_o        <= 1'b0;
                        Valid_o         <= 1'b1;
                        BusErr_o        <= 1'b1;
                        WriteDataAddr_o <= wa_q;
                        WriteData_o     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - randomized self-checking bench for mem_stage_hs against an arithmetic reference model
module tb_mem_stage_hs;

    localparam logic [4:0] OP_LW = 5'b10100, OP_SW = 5'b10101, OP_LB = 5'b10110, OP_LH = 5'b10111;
    localparam logic [4:0] OP_LBU = 5'b11000, OP_LHU = 5'b11001, OP_SB = 5'b11010, OP_SH = 5'b11011;
    localparam int MAX_WAIT = 15;

    logic        clk = 0;
    logic        rst = 1;
    logic        Valid_i = 0, WriteReg_i = 0, MemAck_i = 0;
    logic [4:0]  ALUop_i = 0, WriteDataAddr_i = 0;
    logic [31:0] WriteData_i = 0, MemAddr_i = 0, Reg_i = 0, MemData_i = 0;
    logic        Stall_o, MemReq_o, MemWE_o, Valid_o, WriteReg_o, BusErr_o;
    logic [3:0]  MemBE_o;
    logic [31:0] MemAddr_o, MemData_o, WriteData_o;
    logic [4:0]  WriteDataAddr_o;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        stall0, req, we, hold_ok, valid, wreg, err, req_done, stall_done, valid_next;
        logic [3:0]  be;
        logic [31:0] addr, data, wdata;
        logic [4:0]  wa;
        int          busy;
    } obs_t;

    mem_stage_hs dut (
        .clk(clk), .rst(rst), .Valid_i(Valid_i), .ALUop_i(ALUop_i), .WriteReg_i(WriteReg_i),
        .WriteDataAddr_i(WriteDataAddr_i), .WriteData_i(WriteData_i), .MemAddr_i(MemAddr_i),
        .Reg_i(Reg_i), .Stall_o(Stall_o), .MemReq_o(MemReq_o), .MemWE_o(MemWE_o), .MemBE_o(MemBE_o),
        .MemAddr_o(MemAddr_o), .MemData_o(MemData_o), .MemAck_i(MemAck_i), .MemData_i(MemData_i),
        .Valid_o(Valid_o), .WriteReg_o(WriteReg_o), .WriteDataAddr_o(WriteDataAddr_o),
        .WriteData_o(WriteData_o), .BusErr_o(BusErr_o)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input logic [4:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic is_ld(input logic [4:0] op);
        return op == OP_LW || op == OP_LB || op == OP_LH || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic logic model_misaligned(input logic [4:0] op, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
        return (addr % size_of(op)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_lane(input logic [4:0] op, input logic [31:0] addr);
        int n = size_of(op);
        return ((addr % 4) / n) * n;
    endfunction

    function automatic logic [3:0] model_be(input logic [4:0] op, input logic [31:0] addr);
        int v = ((1 << size_of(op)) - 1) << model_lane(op, addr);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] r);
        logic [63:0] mask = (64'd1 << (8 * size_of(op))) - 1;
        logic [63:0] v = ({32'd0, r} & mask) << (8 * model_lane(op, addr));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rd);
        logic [63:0] mask = (64'd1 << (8 * size_of(op))) - 1;
        logic [63:0] v = ({32'd0, rd} >> (8 * model_lane(op, addr))) & mask;
        logic [63:0] top = (mask + 1) >> 1;
        if ((op == OP_LB || op == OP_LH) && (v & top) != 0) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_mem(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] regv,
                           input logic wreg, input logic [4:0] wa, input logic [31:0] rdata,
                           input int ack_after, output obs_t o);
        @(posedge clk); #1;
        Valid_i = 1; ALUop_i = op; MemAddr_i = addr; Reg_i = regv; WriteReg_i = wreg;
        WriteDataAddr_i = wa; WriteData_i = $urandom;
        #1 o.stall0 = Stall_o;
        @(posedge clk); #1;
        o.req = MemReq_o; o.we = MemWE_o; o.be = MemBE_o; o.addr = MemAddr_o; o.data = MemData_o;
        o.hold_ok = 1; o.busy = 0;
        while (!Valid_o && o.busy < 100) begin
            if (!(MemReq_o === 1'b1 && Stall_o === 1'b1 && MemAddr_o === o.addr && MemBE_o === o.be && MemData_o === o.data))
                o.hold_ok = 0;
            if (o.busy == ack_after) begin MemAck_i = 1; MemData_i = rdata; end
            @(posedge clk); #1;
            MemAck_i = 0; MemData_i = $urandom;
            o.busy++;
        end
        o.valid = Valid_o; o.wreg = WriteReg_o; o.wa = WriteDataAddr_o; o.wdata = WriteData_o;
        o.err = BusErr_o; o.req_done = MemReq_o; o.stall_done = Stall_o;
        Valid_i = 0; ALUop_i = 0;
        @(posedge clk); #1;
        o.valid_next = Valid_o;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (Valid_o !== 0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid_o); end
        n_checks++; if (MemReq_o !== 0) begin n_fail++; $display("FAIL reset_req: got %b want 0", MemReq_o); end
        n_checks++; if (Stall_o !== 0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall_o); end
        n_checks++; if ({MemBE_o, MemAddr_o, MemData_o, WriteData_o, WriteReg_o, BusErr_o, MemWE_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: be=%h addr=%h data=%h wd=%h want all 0", MemBE_o, MemAddr_o, MemData_o, WriteData_o);
        end
        rst = 0;
    endtask

    task automatic test_alu();
        logic [31:0] pd; logic [4:0] pa; logic pw;
        @(posedge clk); #1;
        Valid_i = 1; ALUop_i = 5'b00000; WriteData_i = 32'h1234; WriteReg_i = 1; WriteDataAddr_i = 5'd7;
        #1 n_checks++; if (Stall_o !== 0) begin n_fail++; $display("FAIL add_stall: got %b want 0", Stall_o); end
        @(posedge clk); #1;
        n_checks++; if (Valid_o !== 1 || WriteData_o !== 32'h1234 || WriteReg_o !== 1 || WriteDataAddr_o !== 5'd7) begin
            n_fail++; $display("FAIL add_result: valid=%b data=%h wr=%b wa=%0d want 1 1234 1 7", Valid_o, WriteData_o, WriteReg_o, WriteDataAddr_o);
        end
        for (int i = 0; i < 20; i++) begin
            pd = $urandom; pa = 5'($urandom); pw = 1'($urandom);
            Valid_i = 1; ALUop_i = 5'($urandom_range(0, 19)); WriteData_i = pd; WriteDataAddr_i = pa; WriteReg_i = pw;
            #1 n_checks++; if (Stall_o !== 0) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, Stall_o); end
            @(posedge clk); #1;
            n_checks++; if (Valid_o !== 1 || WriteData_o !== pd || WriteDataAddr_o !== pa || WriteReg_o !== pw) begin
                n_fail++; $display("FAIL b2b_result[%0d]: valid=%b data=%h wa=%0d wr=%b want 1 %h %0d %b", i, Valid_o, WriteData_o, WriteDataAddr_o, WriteReg_o, pd, pa, pw);
            end
        end
        Valid_i = 0;
        @(posedge clk); #1;
        n_checks++; if (Valid_o !== 0) begin n_fail++; $display("FAIL alu_idle_valid: got %b want 0", Valid_o); end
    endtask

    task automatic test_store_byte();
        obs_t o;
        run_mem(OP_SB, 32'h103, 32'h0000_00AB, 1'b1, 5'd3, 32'h0, 3, o);
        n_checks++; if (o.stall0 !== 1) begin n_fail++; $display("FAIL sb_stall_issue: got %b want 1", o.stall0); end
        n_checks++; if (o.req !== 1 || o.we !== 1) begin n_fail++; $display("FAIL sb_req_we: got %b%b want 11", o.req, o.we); end
        n_checks++; if (o.be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", o.be); end
        n_checks++; if (o.data[31:24] !== 8'hAB) begin n_fail++; $display("FAIL sb_lane_data: got %h want ab", o.data[31:24]); end
        n_checks++; if (o.addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr: got %h want 00000100", o.addr); end
        n_checks++; if (o.busy !== 4 || o.valid !== 1) begin n_fail++; $display("FAIL sb_latency: busy=%0d valid=%b want 4 1", o.busy, o.valid); end
        n_checks++; if (o.wreg !== 0 || o.err !== 0) begin n_fail++; $display("FAIL sb_wreg_err: got %b%b want 00", o.wreg, o.err); end
        n_checks++; if (o.hold_ok !== 1) begin n_fail++; $display("FAIL sb_hold: got %b want 1", o.hold_ok); end
        n_checks++; if (o.req_done !== 0 || o.stall_done !== 0 || o.valid_next !== 0) begin
            n_fail++; $display("FAIL sb_done: req=%b stall=%b vnext=%b want 000", o.req_done, o.stall_done, o.valid_next);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        run_mem(OP_LB, 32'h101, 32'h0, 1'b1, 5'd9, 32'h0000_8000, 0, o);
        n_checks++; if (o.wdata !== 32'hFFFF_FF80 || o.wreg !== 1 || o.wa !== 5'd9) begin
            n_fail++; $display("FAIL lb_sext: data=%h wr=%b wa=%0d want ffffff80 1 9", o.wdata, o.wreg, o.wa);
        end
        n_checks++; if (o.busy !== 1 || o.we !== 0 || o.be !== 4'b0010) begin n_fail++; $display("FAIL lb_min_latency: busy=%0d we=%b be=%b want 1 0 0010", o.busy, o.we, o.be); end
        run_mem(OP_LBU, 32'h101, 32'h0, 1'b1, 5'd9, 32'h0000_8000, 2, o);
        n_checks++; if (o.wdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", o.wdata); end
        run_mem(OP_LH, 32'h2, 32'h0, 1'b1, 5'd1, 32'h8001_0000, 1, o);
        n_checks++; if (o.wdata !== 32'hFFFF_8001 || o.be !== 4'b1100) begin n_fail++; $display("FAIL lh_sext: data=%h be=%b want ffff8001 1100", o.wdata, o.be); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_mem(OP_LW, 32'h40, 32'h0, 1'b1, 5'd4, 32'h0, -1, o);
        n_checks++; if (o.busy !== MAX_WAIT) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", o.busy, MAX_WAIT); end
        n_checks++; if (o.err !== 1 || o.valid !== 1 || o.wreg !== 0) begin
            n_fail++; $display("FAIL timeout_result: err=%b valid=%b wr=%b want 1 1 0", o.err, o.valid, o.wreg);
        end
        n_checks++; if (o.req_done !== 0 || o.valid_next !== 0) begin n_fail++; $display("FAIL timeout_drop: req=%b vnext=%b want 0 0", o.req_done, o.valid_next); end
    endtask

    task automatic test_reset_busy();
        int bad_cycles = 0;
        @(posedge clk); #1;
        Valid_i = 1; ALUop_i = OP_LW; MemAddr_i = 32'h80; WriteReg_i = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1; Valid_i = 0; ALUop_i = 0;
        @(posedge clk); #1;
        rst = 0;
        n_checks++; if (MemReq_o !== 0 || Valid_o !== 0 || Stall_o !== 0) begin
            n_fail++; $display("FAIL rst_busy_drop: req=%b valid=%b stall=%b want 000", MemReq_o, Valid_o, Stall_o);
        end
        MemAck_i = 1; MemData_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        MemAck_i = 0;
        repeat (5) begin
            if (Valid_o !== 0 || MemReq_o !== 0 || BusErr_o !== 0 || WriteReg_o !== 0) bad_cycles++;
            @(posedge clk); #1;
        end
        n_checks++; if (bad_cycles !== 0) begin n_fail++; $display("FAIL late_ack_ignored: %0d active cycles want 0", bad_cycles); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [4:0] ops[8] = '{OP_LW, OP_SW, OP_LB, OP_LH, OP_LBU, OP_LHU, OP_SB, OP_SH};
        for (int i = 0; i < 40; i++) begin
            logic [4:0] op = ops[$urandom_range(0, 7)];
            logic [31:0] addr = $urandom, regv = $urandom, rd = $urandom;
            logic wreg = 1'($urandom);
            logic [4:0] wa = 5'($urandom);
            int ack = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 5));
            logic mis = model_misaligned(op, addr);
            logic err = mis || ack >= MAX_WAIT;
            int exp_busy = mis ? 0 : (ack >= MAX_WAIT ? MAX_WAIT : ack + 1);
            run_mem(op, addr, regv, wreg, wa, rd, ack, o);
            n_checks++; if (o.stall0 !== 1) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want 1", i, o.stall0); end
            n_checks++; if (o.busy !== exp_busy || o.valid !== 1 || o.err !== err) begin
                n_fail++; $display("FAIL rnd_timing[%0d]: busy=%0d valid=%b err=%b want %0d 1 %b", i, o.busy, o.valid, o.err, exp_busy, err);
            end
            if (!mis) begin
                n_checks++; if (o.req !== 1 || o.we !== !is_ld(op) || o.be !== model_be(op, addr) || o.addr !== {addr[31:2], 2'b00}) begin
                    n_fail++; $display("FAIL rnd_bus[%0d]: req=%b we=%b be=%b addr=%h want 1 %b %b %h", i, o.req, o.we, o.be, o.addr, !is_ld(op), model_be(op, addr), {addr[31:2], 2'b00});
                end
                n_checks++; if (o.hold_ok !== 1 || o.req_done !== 0) begin n_fail++; $display("FAIL rnd_hold[%0d]: hold=%b req_done=%b want 1 0", i, o.hold_ok, o.req_done); end
                if (!is_ld(op)) begin
                    n_checks++; if (o.data !== model_store(op, addr, regv)) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o.data, model_store(op, addr, regv)); end
                end
            end else begin
                n_checks++; if (o.req !== 0) begin n_fail++; $display("FAIL rnd_misalign_req[%0d]: got %b want 0", i, o.req); end
            end
            n_checks++; if (o.wreg !== (is_ld(op) && !err && wreg)) begin n_fail++; $display("FAIL rnd_wreg[%0d]: got %b want %b", i, o.wreg, is_ld(op) && !err && wreg); end
            if (is_ld(op) && !err) begin
                n_checks++; if (o.wdata !== model_load(op, addr, rd) || o.wa !== wa) begin
                    n_fail++; $display("FAIL rnd_load[%0d]: data=%h wa=%0d want %h %0d", i, o.wdata, o.wa, model_load(op, addr, rd), wa);
                end
            end
            n_checks++; if (o.valid_next !== 0) begin n_fail++; $display("FAIL rnd_single_valid[%0d]: got %b want 0", i, o.valid_next); end
        end
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        obs_t o;
        run_mem(OP_LW, 32'h2, 32'h0, 1'b1, 5'd5, 32'h0, 0, o);
        n_checks++; if (o.req !== 0 || o.err !== 1 || o.valid !== 1 || o.wreg !== 0) begin
            n_fail++; $display("FAIL misalign_lw: req=%b err=%b valid=%b wr=%b want 0 1 1 0", o.req, o.err, o.valid, o.wreg);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_store_byte();
        test_loads();
        test_timeout();
        test_reset_busy();
`ifdef MEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
